// File: rtl/wb_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_pkg
// Shared definitions for the i2d interconnect round-robin arbiter:
//   INTERCON_MASTER_NUM  - number of bus masters on the interconnect
//   WB_BUS_WIDTH         - Wishbone data bus width of the interconnect
//   DEFAULT_TIMEOUT      - default stalled-strobe cycles before the watchdog fires
//   DEFAULT_TO_WIDTH     - default watchdog counter width
//   arb_state_e          - IDLE / OWNED state encodings
//   idx_width()          - index width for a master count (never below 1 bit)
// -----------------------------------------------------------------------------
package wb_rr_arbiter_pkg;

    localparam int INTERCON_MASTER_NUM = 2;
    localparam int WB_BUS_WIDTH        = 32;
    localparam int DEFAULT_TIMEOUT     = 255;
    localparam int DEFAULT_TO_WIDTH    = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // A single master still needs a 1-bit owner index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_if
// Arbitration signals between the interconnect and the arbiter.
//   request[MASTER_NUM] - per-master cyc_o
//   stb, ack, err, rty  - granted master's strobe and slave terminations (muxed)
//   grant[MASTER_NUM]   - registered one-hot grant, zero when idle
//   busy                - any grant bit set
//   timeout_err         - one-cycle watchdog pulse
// Modports: slave = arbiter side, master = interconnect side.
// -----------------------------------------------------------------------------
interface wb_rr_arbiter_if
    import wb_rr_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = INTERCON_MASTER_NUM
);
    logic [MASTER_NUM-1:0] request;
    logic                  stb;
    logic                  ack;
    logic                  err;
    logic                  rty;
    logic [MASTER_NUM-1:0] grant;
    logic                  busy;
    logic                  timeout_err;

    modport slave (
        input  request, stb, ack, err, rty,
        output grant, busy, timeout_err
    );

    modport master (
        output request, stb, ack, err, rty,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/wb_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_arb_rr_pick
// Combinational rotating-priority picker. Search starts at owner+1 (mod
// MASTER_NUM) and the first set request bit wins.
//   request_i  - per-master requests
//   owner_i    - index of current / most recent grantee
//   pick_o     - one-hot winner (zero if no request)
//   pick_idx_o - index of the winner
//   any_o      - at least one request present
// -----------------------------------------------------------------------------
module wb_arb_rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = INTERCON_MASTER_NUM,
    parameter int IDX_W      = idx_width(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] request_i,
    input  logic [IDX_W-1:0]      owner_i,
    output logic [MASTER_NUM-1:0] pick_o,
    output logic [IDX_W-1:0]      pick_idx_o,
    output logic                  any_o
);
    localparam int                DW       = idx_width(2 * MASTER_NUM);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MASTER_NUM - 1);

    // Requests repeated twice: reading MASTER_NUM bits from 'start' upwards
    // walks every master once in rotated order without a modulo per bit.
    logic [2*MASTER_NUM-1:0] dbl;
    logic [IDX_W-1:0]        start;
    int                      sum;

    always_comb begin
        // NOTE: every output gets a default before any branch so the block
        // cannot infer a latch when no request is set.
        pick_idx_o = '0;
        any_o      = 1'b0;
        sum        = 0;
        dbl        = {request_i, request_i};
        start      = (owner_i == LAST_IDX) ? '0 : owner_i + 1'b1;
        // Descending scan so the lowest rotated position is written last and wins.
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (dbl[DW'(int'(start) + i)]) begin
                sum = int'(start) + i;
                if (sum >= MASTER_NUM) sum = sum - MASTER_NUM;
                pick_idx_o = IDX_W'(sum);
                any_o      = 1'b1;
            end
        end
        pick_o = any_o ? (MASTER_NUM'(1) << pick_idx_o) : '0;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin Wishbone bus arbiter with optional bus watchdog.
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - wb_rr_arbiter_if.slave (request/stb/ack/err/rty in,
//          grant/busy/timeout_err out)
// Parameters: MASTER_NUM, TIMEOUT (1 .. 2^TO_WIDTH-1), TO_WIDTH.
// Build option: define WB_ARB_WATCHDOG_EN to implement the watchdog; otherwise
// timeout_err is tied low and stb/ack/err/rty are ignored.
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = INTERCON_MASTER_NUM,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int TO_WIDTH   = DEFAULT_TO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    wb_rr_arbiter_if.slave   bus
);
    localparam int               IDX_W    = idx_width(MASTER_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MASTER_NUM - 1);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      owner_q;
    logic [MASTER_NUM-1:0] grant_q;

    logic [MASTER_NUM-1:0] pick;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  owner_req;

    wb_arb_rr_pick #(
        .MASTER_NUM (MASTER_NUM),
        .IDX_W      (IDX_W)
    ) u_pick (
        .request_i  (bus.request),
        .owner_i    (owner_q),
        .pick_o     (pick),
        .pick_idx_o (pick_idx),
        .any_o      (pick_any)
    );

    assign owner_req = bus.request[owner_q];

    // Owner resets to the last master so master 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= LAST_IDX;
            grant_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_q <= ARB_OWNED;
                        owner_q <= pick_idx;
                        grant_q <= pick;
                    end
                end
                ARB_OWNED: begin
                    // Current owner is never preempted while it still requests.
                    if (!owner_req) begin
                        if (pick_any) begin
                            owner_q <= pick_idx;
                            grant_q <= pick;
                        end else begin
                            state_q <= ARB_IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q == ARB_OWNED);

`ifdef WB_ARB_WATCHDOG_EN
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] TO_MAX  = TO_WIDTH'(TIMEOUT);

    logic [TO_WIDTH-1:0] to_cnt_q;
    logic                timeout_q;
    logic                handover;
    logic                stall_clear;

    assign handover    = (state_q == ARB_OWNED) && !owner_req && pick_any;
    assign stall_clear = (state_q == ARB_IDLE) || !bus.stb ||
                         bus.ack || bus.err || bus.rty || handover;

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (stall_clear) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_LAST) begin
                // Fire and restart so a continuing stall repeats every TIMEOUT cycles.
                timeout_q <= 1'b1;
                to_cnt_q  <= '0;
            end else if (to_cnt_q != TO_MAX) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    logic unused_wd;
    assign unused_wd       = ^{bus.stb, bus.ack, bus.err, bus.rty};
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Directed stimulus for wb_rr_arbiter (MASTER_NUM=2, TIMEOUT=4). Each driven
// cycle pushes the expected post-edge outputs into a scoreboard queue; a
// monitor pops one entry per clock and compares grant/busy/timeout_err.
// Watchdog expectations follow WB_ARB_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

`ifdef WB_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [1:0] grant;
        logic       to;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    bit   fair_on;
    int   fair_cnt0;
    int   fair_cnt1;

    wb_rr_arbiter_if #(.MASTER_NUM(2)) bus ();

    wb_rr_arbiter #(
        .MASTER_NUM (2),
        .TIMEOUT    (4),
        .TO_WIDTH   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge and queue the outputs expected after
    // the next rising edge.
    task automatic step(input string name, input bit rst_v, input bit [1:0] req,
                        input bit stb_v, input bit ack_v, input bit [1:0] eg, input bit eto);
        exp_t e;
        @(negedge clk);
        rst         = rst_v;
        bus.request = req;
        bus.stb     = stb_v;
        bus.ack     = ack_v;
        e.name      = name;
        e.grant     = eg;
        e.to        = eto;
        sb_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 ns after it.
    initial begin
        exp_t       e;
        logic [1:0] prev_grant;
        prev_grant = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, "_grant"}, 32'(bus.grant), 32'(e.grant));
                check({e.name, "_busy"}, 32'(bus.busy), 32'(|e.grant));
                check({e.name, "_tmo"}, 32'(bus.timeout_err), 32'(e.to));
                if (fair_on) begin
                    if (bus.grant[0] && !prev_grant[0]) fair_cnt0++;
                    if (bus.grant[1] && !prev_grant[1]) fair_cnt1++;
                end
                prev_grant = bus.grant;
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        fair_on     = 1'b0;
        fair_cnt0   = 0;
        fair_cnt1   = 0;
        rst         = 1'b0;
        bus.request = 2'b11;
        bus.stb     = 1'b0;
        bus.ack     = 1'b0;
        bus.err     = 1'b0;
        bus.rty     = 1'b0;

        // Reset held with both masters requesting: bus stays idle.
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        // Master 0 has first priority after reset.
        step("first", 1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0);
        // Contention: master 0 holds, then drops -> direct handover.
        for (int i = 0; i < 3; i++) step("hold0", 1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0);
        step("handover", 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0);
        step("hold1", 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0);
        step("idle", 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        // Release: only master 1, then drop; owner=1 so master 0 wins next.
        step("rel_grant", 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0);
        step("rel_drop", 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        step("rel_next", 1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0);
        step("rel_idle", 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        // Watchdog: stalled strobe fires after cycles 4 and 8.
        step("wd_grant", 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0);
        for (int k = 1; k <= 8; k++)
            step("wd_stall", 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, WD && (k == 4 || k == 8));
        // Ack on cycle 3 restarts the count; the strobe ends before it fires.
        for (int k = 1; k <= 6; k++)
            step("wd_ack", 1'b1, 2'b01, 1'b1, k == 3, 2'b01, 1'b0);
        step("wd_stb_low", 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0);
        // Mid-transfer reset with master 1 granted and the counter at 3.
        step("mr_handover", 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0);
        for (int k = 1; k <= 3; k++) step("mr_stall", 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0);
        step("mr_reset", 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
        step("mr_reset2", 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
        step("mr_after", 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        step("mr_after2", 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        // Fairness: both masters toggle together every 3 cycles; owner alternates.
        fair_on = 1'b1;
        for (int p = 0; p < 33; p++) begin
            for (int s = 0; s < 6; s++)
                step("fair", 1'b1, (s < 3) ? 2'b11 : 2'b00, 1'b0, 1'b0,
                     (s < 3) ? ((p % 2 == 1) ? 2'b10 : 2'b01) : 2'b00, 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        fair_on = 1'b0;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        check("fair_diff_le1", 32'((fair_cnt0 - fair_cnt1 <= 1) && (fair_cnt1 - fair_cnt0 <= 1)), 32'd1);
        check("fair_total", 32'(fair_cnt0 + fair_cnt1), 32'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
